// File: rtl/aux_perf_ctr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : aux_perf_ctr_bank
//  Description : Bank of NumCh independent event counters with a RUN/HALTED
//                gate, snapshot shadow registers, registered shadow readout
//                and sticky per-channel overflow flags.
//                Optional macro AUX_PERF_CTR_SAT_EN: counters saturate at
//                all-ones instead of wrapping to zero (overflow still flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module aux_perf_ctr_bank #(
    parameter int NumCh  = 8,
    parameter int CntBit = 32,
    parameter int SelBit = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              halt,
    input  logic              resume,
    input  logic [NumCh-1:0]  ev,
    input  logic              clr,
    input  logic              snap,
    input  logic [SelBit-1:0] sel,
    output logic [CntBit-1:0] rd_data,
    output logic [NumCh-1:0]  ovf,
    output logic              running
);

`ifdef AUX_PERF_CTR_SAT_EN
    localparam logic c_SAT_EN = 1'b1;
`else
    localparam logic c_SAT_EN = 1'b0;
`endif

    localparam logic [CntBit-1:0] c_ONE = CntBit'(1);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_resume_q;
    logic               w_resume_rise;
    logic               w_cnt_en;
    logic [CntBit-1:0]  r_cnt    [NumCh];
    logic [CntBit-1:0]  r_shadow [NumCh];
    logic [NumCh-1:0]   r_ovf;
    logic [CntBit-1:0]  r_rd_data;
    logic [CntBit-1:0]  w_rd_mux;

    assign w_resume_rise = resume & ~r_resume_q;
    // Counting is permitted in the cycle halt is sampled, since the state
    // only leaves RUN at the following edge.
    assign w_cnt_en      = (r_state == S_RUN) & en;

    // State register and resume edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_resume_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_resume_q <= resume;
        end
    end

    // Next-state logic: halt always wins over a coincident resume edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (w_resume_rise && !halt) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Counters, shadows and sticky overflow; clr overrides snap and counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumCh; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < NumCh; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (snap) begin
                    r_shadow[i] <= r_cnt[i];
                end
                if (w_cnt_en && ev[i]) begin
                    if (&r_cnt[i]) begin
                        r_ovf[i] <= 1'b1;
                        if (!c_SAT_EN) begin
                            r_cnt[i] <= '0;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + c_ONE;
                    end
                end
            end
        end
    end

    // Readout mux: any select without a matching channel reads as zero
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (sel == SelBit'(i)) begin
                w_rd_mux = r_shadow[i];
            end
        end
    end

    // Registered readout, one cycle behind the shadow contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data = r_rd_data;
    assign ovf     = r_ovf;
    assign running = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: doc/aux_perf_ctr_bank.md
AUX_PERF_CTR_BANK -- requirements
Module: AuxPerfCtrBank

Interface
REQ-001 SHALL have parameter NumCh, default 8, the number of event counter channels (1..32).
REQ-002 SHALL have parameter CntBit, default 32, the width of each counter (4..32).
REQ-003 SHALL have parameter SelBit, default 3, the readout select width; 2^SelBit >= NumCh.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk in and rst in.
REQ-005 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1, global count enable (core enable).
REQ-008 SHALL have port halt, input, 1, level request to stop counting.
REQ-009 SHALL have port resume, input, 1, level input, edge-detected internally.
REQ-010 SHALL have port ev, input, NumCh, per-channel event strobes.
REQ-011 SHALL have port clr, input, 1, synchronous clear of all counters, shadows and flags.
REQ-012 SHALL have port snap, input, 1, copies all live counters into shadow registers.
REQ-013 SHALL have port sel, input, SelBit, readout channel select.
REQ-014 SHALL have port rd_data, output, CntBit, registered shadow readout.
REQ-015 SHALL have port ovf, output, NumCh, sticky per-channel overflow flags.
REQ-016 SHALL have port running, output, 1, high while the FSM is in RUN.

Function
REQ-017 SHALL implement a 2-state FSM, RUN and HALTED; running = (state == RUN).
REQ-018 In RUN with halt=1, the FSM SHALL go to HALTED at the next edge; counting is still permitted in that halt cycle.
REQ-019 In HALTED, a resume rising edge (resume=1, registered previous resume=0) SHALL move the FSM to RUN; if halt=1 in the same cycle, the FSM SHALL stay in HALTED.
REQ-020 Channel i SHALL increment by 1 at an edge only when state==RUN, en=1 and ev[i]=1; all channels are independent.
REQ-021 snap=1 SHALL load shadow[i] with the pre-edge live value of counter i, for every i.
REQ-022 clr=1 SHALL zero all counters, shadows and ovf at the next edge, overriding a same-cycle increment and snap.
REQ-023 clr SHALL NOT change the FSM state.
REQ-024 rd_data SHALL be loaded with shadow[sel] at each edge (1-cycle latency); sel >= NumCh SHALL give 0.
REQ-025 If snap and sel change in the same cycle, rd_data SHALL show the new shadow value one cycle after the snap edge.
REQ-026 ovf[i] SHALL set when an increment is applied to a counter at all-ones, and stay set until clr or rst.
REQ-027 Wrap behaviour (macro absent): a counter at all-ones SHALL become 0 on increment.

Reset
REQ-028 rst SHALL asynchronously force state=RUN, all counters=0, shadows=0, ovf=0, rd_data=0 and the resume history register=0.
REQ-029 rst asserted in mid-operation SHALL override clr, snap and all increments in that cycle.

Configuration
REQ-030 With macro AUX_PERF_CTR_SAT_EN defined, a counter at all-ones SHALL hold at all-ones on increment, and ovf[i] SHALL still set.
REQ-031 Without AUX_PERF_CTR_SAT_EN, REQ-027 wrap behaviour SHALL apply; there is no other difference.

Verification
REQ-032 NumCh=8: rst, en=1, ev=8'h05 for 10 cycles, snap, sel=2 -> rd_data=10 one cycle after the snap edge; sel=1 -> 0.
REQ-033 CntBit=4: 17 events on ch0 -> without macro, counter=1 and ovf[0]=1; with macro, counter=15 and ovf[0]=1.
REQ-034 halt=1 for 1 cycle with ev[0]=1 held -> exactly 1 count in the halt cycle, then running=0 and no counts; resume 0->1 -> running=1 next edge, counting resumes.
REQ-035 In HALTED, resume held at 1 with no new rising edge -> stays HALTED; resume rising with halt=1 -> stays HALTED.
REQ-036 clr, snap and ev=8'hFF in the same cycle -> all counters, shadows and ovf are 0; running is unchanged.
REQ-037 rst pulse with counters at 5 -> all outputs 0 immediately, asynchronously, and running=1.
